// File: rtl/font_cell_scheduler.sv
// font_cell_scheduler
//   Walks the text screen cell by cell. For every cell it reads the cell word
//   from text RAM, then the glyph from font ROM, and stages the result. It
//   hands the staged cell to the pixel renderer with a one-cycle font_ready
//   pulse. Both memories are synchronous-read, so data returns one cycle
//   after the address. Fetching the next cell overlaps with rendering of the
//   current one.
//
//   State table:
//     IDLE  | waiting for start; busy low
//     TEXT  | text_addr presents the current cell to text RAM
//     CODE  | cell word captured; cursor swap applied; font_addr loaded
//     FONT  | font_addr held while font ROM reads the glyph
//     SHAPE | glyph captured into staging
//     WAIT  | waiting for the renderer before handing the staged cell over
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             one-cycle frame request (ignored while busy)
//   cursor_en/col/row cursor position; sampled when each cell is staged
//   text_addr/data    text RAM read port (row*TEXT_COLS+col)
//   font_addr/data    font ROM read port (char code -> 128-bit glyph)
//   render_done       renderer idle
//   font_ready        hand-off pulse; grid_* and base_address valid next cycle
//   grid_shape/fg/bg  live cell for the renderer
//   base_address      framebuffer address of the cell's top-left pixel
//   busy, frame_done  frame in progress / end-of-frame pulse
module font_cell_scheduler #(
  parameter int TEXT_COLS = 80,
  parameter int TEXT_ROWS = 30,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int SCREEN_W  = 640
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cursor_en,
  input  logic [6:0]   cursor_col,
  input  logic [4:0]   cursor_row,
  output logic [11:0]  text_addr,
  input  logic [31:0]  text_data,
  output logic [7:0]   font_addr,
  input  logic [127:0] font_data,
  input  logic         render_done,
  output logic         font_ready,
  output logic [127:0] grid_shape,
  output logic [11:0]  grid_fg,
  output logic [11:0]  grid_bg,
  output logic [19:0]  base_address,
  output logic         busy,
  output logic         frame_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TEXT  = 3'd1;
  localparam logic [2:0] CODE  = 3'd2;
  localparam logic [2:0] FONT  = 3'd3;
  localparam logic [2:0] SHAPE = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;

  localparam logic [6:0]  LAST_COL = 7'(TEXT_COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(TEXT_ROWS - 1);
  localparam logic [19:0] ROW_STEP = 20'(CHAR_H * SCREEN_W);
  localparam logic [19:0] COL_STEP = 20'(CHAR_W);

  logic [2:0]   state;
  logic [6:0]   col;
  logic [4:0]   row;
  logic         busySeen;
  logic [11:0]  fgStage;
  logic [11:0]  bgStage;
  logic [127:0] shapeStage;
  logic [19:0]  baseStage;
  logic         cursorHit;
  logic         handoff;

  assign cursorHit  = cursor_en && (col == cursor_col) && (row == cursor_row);
  assign handoff    = (state == WAIT) && render_done && busySeen;
  assign font_ready = handoff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      busySeen     <= 1'b0;
      fgStage      <= '0;
      bgStage      <= '0;
      shapeStage   <= '0;
      baseStage    <= '0;
      text_addr    <= '0;
      font_addr    <= '0;
      grid_shape   <= '0;
      grid_fg      <= '0;
      grid_bg      <= '0;
      base_address <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // The renderer needs the cycle after font_ready to sample the cell and
      // drop render_done, so busySeen stays clear for exactly that cycle.
      // Any later cycle outside WAIT, or any cycle with render_done low,
      // re-arms it; WAIT is never reached sooner than four cycles later.
      if (state == IDLE && start)
        busySeen <= 1'b1;
      else if (handoff)
        busySeen <= 1'b0;
      else if (!render_done || state != WAIT)
        busySeen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            col       <= '0;
            row       <= '0;
            text_addr <= '0;
            busy      <= 1'b1;
            state     <= TEXT;
          end
        end
        TEXT: state <= CODE;
        CODE: begin
          font_addr <= text_data[7:0];
          if (cursorHit) begin
            fgStage <= text_data[31:20];
            bgStage <= text_data[19:8];
          end else begin
            fgStage <= text_data[19:8];
            bgStage <= text_data[31:20];
          end
          baseStage <= 20'(row) * ROW_STEP + 20'(col) * COL_STEP;
          state     <= FONT;
        end
        FONT: state <= SHAPE;
        SHAPE: begin
          shapeStage <= font_data;
          state      <= WAIT;
        end
        WAIT: begin
          if (handoff) begin
            grid_shape   <= shapeStage;
            grid_fg      <= fgStage;
            grid_bg      <= bgStage;
            base_address <= baseStage;
            // Cells are row-major with pitch TEXT_COLS, so the next text
            // address is always the current one plus one.
            if (col < LAST_COL) begin
              col       <= col + 7'd1;
              text_addr <= text_addr + 12'd1;
              state     <= TEXT;
            end else begin
              col <= '0;
              if (row < LAST_ROW) begin
                row       <= row + 5'd1;
                text_addr <= text_addr + 12'd1;
                state     <= TEXT;
              end else begin
                busy       <= 1'b0;
                frame_done <= 1'b1;
                state      <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_font_cell_scheduler.sv
module tb_font_cell_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cursor_en;
  logic [6:0]   cursor_col;
  logic [4:0]   cursor_row;
  logic [11:0]  text_addr;
  logic [31:0]  text_data;
  logic [7:0]   font_addr;
  logic [127:0] font_data;
  logic         render_done;
  logic         font_ready;
  logic [127:0] grid_shape;
  logic [11:0]  grid_fg;
  logic [11:0]  grid_bg;
  logic [19:0]  base_address;
  logic         busy;
  logic         frame_done;

  int vectors = 0;
  int miscompares = 0;

  font_cell_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .render_done(render_done), .font_ready(font_ready),
    .grid_shape(grid_shape), .grid_fg(grid_fg), .grid_bg(grid_bg),
    .base_address(base_address), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Memory models: cell word = {bg 000, fg FFF, code = addr[7:0]};
  // glyph = char code repeated sixteen times.
  always @(posedge clk) begin
    text_data <= {12'h000, 12'hFFF, text_addr[7:0]};
    font_data <= {16{font_addr}};
  end

  // Monitor: counts pulses and logs the cell loaded by each hand-off,
  // indexed by the text address current at the hand-off.
  int          pulseCount = 0;
  int          frameDoneCount = 0;
  bit          logPending = 1'b0;
  int          logIdx = 0;
  logic [19:0] baseLog [0:2399];
  logic [11:0] fgLog   [0:2399];
  logic [11:0] bgLog   [0:2399];
  logic [127:0] shapeLog [0:2399];

  always @(posedge clk) begin
    if (logPending && logIdx < 2400) begin
      baseLog[logIdx]  = base_address;
      fgLog[logIdx]    = grid_fg;
      bgLog[logIdx]    = grid_bg;
      shapeLog[logIdx] = grid_shape;
    end
    logPending = font_ready;
    if (font_ready) begin
      pulseCount++;
      logIdx = int'(text_addr);
    end
    if (frame_done) frameDoneCount++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input string tag, input int budget);
    int n = 0;
    while (font_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready within budget"}, 128'(font_ready), 128'd1);
  endtask

  task automatic waitFrameDone(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " frame_done within budget"}, 128'(frame_done), 128'd1);
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  int pBase;
  int fBase;
  logic [127:0] shapeA3;

  initial begin
    rst = 1'b0; start = 1'b0; cursor_en = 1'b0; cursor_col = 7'd0;
    cursor_row = 5'd0; render_done = 1'b1;
    shapeA3 = {16{8'hA3}};

    // Reset state
    @(negedge clk);
    check("rst font_ready", 128'(font_ready), 128'd0);
    check("rst busy", 128'(busy), 128'd0);
    check("rst frame_done", 128'(frame_done), 128'd0);
    check("rst text_addr", 128'(text_addr), 128'd0);
    check("rst font_addr", 128'(font_addr), 128'd0);
    check("rst grid_shape", grid_shape, 128'd0);
    check("rst grid_fg", 128'(grid_fg), 128'd0);
    check("rst grid_bg", 128'(grid_bg), 128'd0);
    check("rst base", 128'(base_address), 128'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Frame 1: render_done tied high, cursor off
    pBase = pulseCount; fBase = frameDoneCount;
    pulseStart();
    @(negedge clk);
    check("f1 busy at TEXT", 128'(busy), 128'd1);
    check("f1 text_addr at TEXT", 128'(text_addr), 128'd0);
    check("f1 no ready at TEXT", 128'(font_ready), 128'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("f1 no ready +%0d", k), 128'(font_ready), 128'd0);
      if (k == 2) check("f1 font_addr at FONT", 128'(font_addr), 128'd0);
    end
    @(negedge clk);
    check("f1 ready +4", 128'(font_ready), 128'd1);
    @(negedge clk);
    check("f1 cell0 base", 128'(base_address), 128'd0);
    check("f1 cell0 shape", grid_shape, 128'd0);
    check("f1 cell0 fg", 128'(grid_fg), 128'h000FFF);
    check("f1 cell0 bg", 128'(grid_bg), 128'd0);
    waitFrameDone("f1");
    check("f1 busy drops with frame_done", 128'(busy), 128'd0);
    check("f1 last base", 128'(base_address), 128'd297592);
    check("f1 last text_addr", 128'(text_addr), 128'd2399);
    @(negedge clk);
    check("f1 frame_done one cycle", 128'(frame_done), 128'd0);
    check("f1 pulses", 128'(pulseCount - pBase), 128'd2400);
    check("f1 frame_done count", 128'(frameDoneCount - fBase), 128'd1);
    check("f1 base (79,0)", 128'(baseLog[79]), 128'd632);
    check("f1 base (0,1)", 128'(baseLog[80]), 128'd10240);
    check("f1 base (79,29)", 128'(baseLog[2399]), 128'd297592);
    check("f1 fg (3,2) no cursor", 128'(fgLog[163]), 128'hFFF);
    check("f1 bg (3,2) no cursor", 128'(bgLog[163]), 128'h000);

    // Frame 2: cursor at (3,2)
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
    pulseStart();
    waitFrameDone("f2");
    @(negedge clk);
    check("f2 fg (3,2) swapped", 128'(fgLog[163]), 128'h000);
    check("f2 bg (3,2) swapped", 128'(bgLog[163]), 128'hFFF);
    check("f2 shape (3,2)", shapeLog[163], shapeA3);
    check("f2 fg (2,2)", 128'(fgLog[162]), 128'hFFF);
    check("f2 fg (3,3)", 128'(fgLog[243]), 128'hFFF);
    cursor_en = 1'b0;

    // Frame 3: render_done handshake, start mid-frame, reset mid-frame
    pulseStart();
    waitReady("f3 cell0", 20);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 render_done = (k == 1 || k == 7);
      @(negedge clk);
      check($sformatf("f3 handshake +%0d", k), 128'(font_ready), 128'(k == 7));
    end
    @(negedge clk);
    check("f3 cell1 base", 128'(base_address), 128'd8);
    pulseStart();
    waitReady("f3 cell2", 20);
    @(negedge clk);
    check("f3 start ignored base", 128'(base_address), 128'd16);
    check("f3 still busy", 128'(busy), 128'd1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    pBase = pulseCount; fBase = frameDoneCount;
    @(negedge clk);
    check("mid rst busy", 128'(busy), 128'd0);
    check("mid rst text_addr", 128'(text_addr), 128'd0);
    check("mid rst font_addr", 128'(font_addr), 128'd0);
    check("mid rst grid_shape", grid_shape, 128'd0);
    check("mid rst grid_fg", 128'(grid_fg), 128'd0);
    check("mid rst base", 128'(base_address), 128'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post rst no pulses", 128'(pulseCount - pBase), 128'd0);
    check("post rst no frame_done", 128'(frameDoneCount - fBase), 128'd0);
    check("post rst idle", 128'(busy), 128'd0);
    pulseStart();
    waitReady("restart cell0", 20);
    check("restart text_addr", 128'(text_addr), 128'd0);
    @(negedge clk);
    check("restart base", 128'(base_address), 128'd0);
    check("restart fg", 128'(grid_fg), 128'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/font_cell_scheduler.md
FONT_CELL_SCHEDULER -- requirements
Module: font_cell_scheduler

Interface
REQ-001 SHALL have parameters: TEXT_COLS 80, text columns; TEXT_ROWS 30, text rows; CHAR_W 8, glyph width in pixels; CHAR_H 16, glyph height in pixels; SCREEN_W 640, framebuffer line pitch in pixels.
REQ-002 SHALL have ports (clock and reset first):
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to render the full text screen
cursor_en  in  1  cursor visible
cursor_col  in  7  cursor column
cursor_row  in  5  cursor row
text_addr  out  12  text RAM read address, row*TEXT_COLS+col
text_data  in  32  cell word: [7:0] char code, [19:8] fg RGB444, [31:20] bg RGB444
font_addr  out  8  font ROM read address (char code)
font_data  in  128  glyph bitmap, bit y*CHAR_W+x = pixel (x,y)
render_done  in  1  pixel renderer idle and finished
font_ready  out  1  one-cycle pulse handing a cell to the renderer
grid_shape  out  128  glyph bitmap for renderer
grid_fg  out  12  foreground colour for renderer
grid_bg  out  12  background colour for renderer
base_address  out  20  framebuffer address of the cell's top-left pixel
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last cell handed off

Function
REQ-003 SHALL treat text RAM and font ROM as synchronous reads: data valid the cycle after the address is presented.
REQ-004 SHALL implement states IDLE, TEXT, CODE, FONT, SHAPE, WAIT.
REQ-005 IDLE: on start=1, clear col/row counters to 0, set busy=1, go TEXT; otherwise stay.
REQ-006 TEXT: text_addr = row*TEXT_COLS+col; go CODE.
REQ-007 CODE: capture text_data into staging code/fg/bg registers; go FONT.
REQ-008 FONT: font_addr = staged code, held stable; go SHAPE.
REQ-009 SHAPE: capture font_data into staging shape register; go WAIT.
REQ-010 Cursor: if cursor_en=1 and (col,row)=(cursor_col,cursor_row), staged fg and bg SHALL be swapped; shape unchanged.
REQ-011 WAIT: hand-off SHALL occur only when render_done=1 and the busy_seen flag is set; at hand-off, font_ready=1 for exactly one cycle, and grid_shape/grid_fg/grid_bg/base_address SHALL load from staging on that same edge.
REQ-012 grid_* and base_address SHALL stay constant from a hand-off until the next hand-off (the renderer samples them the cycle after font_ready).
REQ-013 busy_seen SHALL be set on start, cleared on each hand-off, and set in any cycle where render_done=0; render_done=1 in the cycle after a hand-off SHALL NOT trigger another hand-off.
REQ-014 base_address SHALL equal row*CHAR_H*SCREEN_W + col*CHAR_W, computed without truncation in 20 bits (max 297592).
REQ-015 After hand-off: if col<TEXT_COLS-1, col+1 and go TEXT; else col=0 and, if row<TEXT_ROWS-1, row+1 and go TEXT; else go IDLE, busy=0, frame_done=1 for one cycle.
REQ-016 Prefetch of the next cell (TEXT..SHAPE) SHALL proceed while the renderer is busy; staging registers SHALL NOT alter live grid_* outputs.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 Cursor inputs SHALL be sampled in CODE of each cell; changes mid-frame affect only cells not yet staged.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE, counters 0, busy_seen 0, and all outputs 0 (font_ready, frame_done, busy, text_addr, font_addr, grid_*, base_address).
REQ-020 Reset asserted mid-frame SHALL abort the frame with no further font_ready or frame_done pulse.

Verification
REQ-021 start with render_done tied 1 -> first font_ready 4 cycles after TEXT entry; cell (0,0) base_address 0; 2400 pulses total; one frame_done; busy drops the same cycle.
REQ-022 cell (79,0) then (0,1) -> base_address 632 then 10240; last cell (79,29) -> 297592, text_addr 2399.
REQ-023 render_done held 1 through the cycle after each pulse, then 0 for 5 cycles -> no double pulse; next pulse only after render_done returns to 1.
REQ-024 cursor_en=1 at (3,2), cell fg 0xFFF bg 0x000 -> grid_fg 0x000, grid_bg 0xFFF for that cell only; cursor_en=0 -> unswapped.
REQ-025 start pulsed mid-frame, then rst=0 mid-frame -> start has no effect; after reset all outputs 0, IDLE, and a new start renders from (0,0).
